// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues one word request per PC, holds the fetched
// word for the decode stage, and tracks delay slots, pending branches and flushes.
module if_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] exc_pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] PC_plus4,
    output logic [31:0] Instruction,
    output logic        is_delayslot,
    output logic [31:0] if_fetch_exc_type,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD,
        DISCARD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic        aligned;
    logic        take_branch;
    logic        in_slot;
    logic [31:0] pc_next4;

    assign aligned     = (pc[1:0] == 2'b00);
    assign pc_next4    = pc + 32'd4;
    assign inst_req    = (state == ISSUE) && aligned;
    assign inst_addr   = pc;
    assign fetch_stall = (state != HOLD);

    // Only the first branch is kept, and a flush in the same cycle kills it.
    assign take_branch = branch_valid && !pend_valid && !flush;
    // Any branch seen while this word is in flight makes it the delay slot.
    assign in_slot     = pend_valid || take_branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ISSUE;
            pc                <= 32'hBFC0_0000;
            pend_valid        <= 1'b0;
            pend_target       <= 32'h0;
            PC_plus4          <= 32'h0;
            Instruction       <= 32'h0;
            is_delayslot      <= 1'b0;
            if_fetch_exc_type <= 32'h0;
        end else if (flush) begin
            pc           <= exc_pc;
            pend_valid   <= 1'b0;
            is_delayslot <= 1'b0;
            // A request already accepted by memory must have its data drained.
            unique case (state)
                ISSUE:   state <= (inst_req && inst_addr_ok) ? DISCARD : ISSUE;
                WAIT:    state <= inst_data_ok ? ISSUE : DISCARD;
                HOLD:    state <= ISSUE;
                DISCARD: state <= inst_data_ok ? ISSUE : DISCARD;
                default: state <= ISSUE;
            endcase
        end else begin
            if (take_branch) begin
                pend_valid  <= 1'b1;
                pend_target <= branch_target;
            end
            unique case (state)
                ISSUE: begin
                    if (!aligned) begin
                        Instruction       <= 32'h0;
                        PC_plus4          <= pc_next4;
                        if_fetch_exc_type <= 32'h0000_0004;
                        is_delayslot      <= in_slot;
                        state             <= HOLD;
                    end else if (inst_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        Instruction       <= inst_rdata;
                        PC_plus4          <= pc_next4;
                        if_fetch_exc_type <= 32'h0;
                        is_delayslot      <= in_slot;
                        state             <= HOLD;
                    end
                end
                HOLD: begin
                    // A branch arriving as the held word leaves redirects straight away.
                    if (!stall) begin
                        pc         <= pend_valid  ? pend_target   :
                                      take_branch ? branch_target : pc_next4;
                        pend_valid <= 1'b0;
                        state      <= ISSUE;
                    end else if (take_branch) begin
                        is_delayslot <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (inst_data_ok) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed testbench for if_fetch_ctrl: each task drives one scenario and checks
// the fetch interface against hand-computed values.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] exc_pc;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] PC_plus4;
    logic [31:0] Instruction;
    logic        is_delayslot;
    logic [31:0] if_fetch_exc_type;
    logic        fetch_stall;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .exc_pc            (exc_pc),
        .branch_valid      (branch_valid),
        .branch_target     (branch_target),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_addr_ok      (inst_addr_ok),
        .inst_data_ok      (inst_data_ok),
        .inst_rdata        (inst_rdata),
        .PC_plus4          (PC_plus4),
        .Instruction       (Instruction),
        .is_delayslot      (is_delayslot),
        .if_fetch_exc_type (if_fetch_exc_type),
        .fetch_stall       (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One aligned fetch: accepted this cycle, data the next; ends with the word in HOLD.
    task automatic do_fetch(input logic [31:0] data);
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = data;
        cyc();
        inst_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (inst_addr !== 32'hBFC0_0000) begin
            n_bad++; $display("[TB] FAIL reset_addr: got %h want bfc00000", inst_addr);
        end
        n_cmp++;
        if ({inst_req, fetch_stall, is_delayslot} !== 3'b110) begin
            n_bad++; $display("[TB] FAIL reset_flags: got %b want 110", {inst_req, fetch_stall, is_delayslot});
        end
        n_cmp++;
        if ({Instruction, PC_plus4, if_fetch_exc_type} !== 96'h0) begin
            n_bad++; $display("[TB] FAIL reset_regs: got %h %h %h want zeros", Instruction, PC_plus4, if_fetch_exc_type);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        inst_addr_ok = 1'b1;
        n_cmp++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000) begin
            n_bad++; $display("[TB] FAIL basic_req: got %b %h want 1 bfc00000", inst_req, inst_addr);
        end
        cyc();
        inst_addr_ok = 1'b0;
        cyc();
        n_cmp++;
        if (inst_req !== 1'b0 || fetch_stall !== 1'b1) begin
            n_bad++; $display("[TB] FAIL basic_wait: got req=%b stall=%b want 0 1", inst_req, fetch_stall);
        end
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h2408_0001;
        cyc();
        inst_data_ok = 1'b0;
        n_cmp++;
        if (Instruction !== 32'h2408_0001 || PC_plus4 !== 32'hBFC0_0004) begin
            n_bad++; $display("[TB] FAIL basic_data: got %h %h want 24080001 bfc00004", Instruction, PC_plus4);
        end
        n_cmp++;
        if (fetch_stall !== 1'b0 || is_delayslot !== 1'b0 || if_fetch_exc_type !== 32'h0) begin
            n_bad++; $display("[TB] FAIL basic_flags: got %b %b %h want 0 0 0", fetch_stall, is_delayslot, if_fetch_exc_type);
        end
        cyc();
        n_cmp++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0004) begin
            n_bad++; $display("[TB] FAIL basic_next: got %b %h want 1 bfc00004", inst_req, inst_addr);
        end
    endtask

    task automatic test_delayslot();
        do_fetch(32'h0000_1111);
        cyc();
        n_cmp++;
        if (inst_addr !== 32'hBFC0_0008) begin
            n_bad++; $display("[TB] FAIL ds_addr8: got %h want bfc00008", inst_addr);
        end
        // Branch during the request; a second branch during data must lose.
        inst_addr_ok  = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 32'hBFC0_0100;
        cyc();
        inst_addr_ok  = 1'b0;
        branch_target = 32'hBFC0_0200;
        inst_data_ok  = 1'b1;
        inst_rdata    = 32'h0000_2222;
        cyc();
        inst_data_ok  = 1'b0;
        branch_valid  = 1'b0;
        n_cmp++;
        if (Instruction !== 32'h0000_2222 || is_delayslot !== 1'b1 || PC_plus4 !== 32'hBFC0_000C) begin
            n_bad++; $display("[TB] FAIL ds_slot: got %h %b %h want 00002222 1 bfc0000c", Instruction, is_delayslot, PC_plus4);
        end
        cyc();
        n_cmp++;
        if (inst_addr !== 32'hBFC0_0100) begin
            n_bad++; $display("[TB] FAIL ds_target: got %h want bfc00100", inst_addr);
        end
        do_fetch(32'h0000_3333);
        n_cmp++;
        if (is_delayslot !== 1'b0 || PC_plus4 !== 32'hBFC0_0104) begin
            n_bad++; $display("[TB] FAIL ds_after: got %b %h want 0 bfc00104", is_delayslot, PC_plus4);
        end
        cyc();
    endtask

    task automatic test_stall();
        do_fetch(32'h0000_4444);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (Instruction !== 32'h0000_4444 || PC_plus4 !== 32'hBFC0_0108 ||
                inst_req !== 1'b0 || fetch_stall !== 1'b0) begin
                n_bad++; $display("[TB] FAIL stall_hold%0d: got %h %h req=%b fs=%b want 00004444 bfc00108 0 0",
                                  i, Instruction, PC_plus4, inst_req, fetch_stall);
            end
        end
        stall = 1'b0;
        cyc();
        n_cmp++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0108) begin
            n_bad++; $display("[TB] FAIL stall_release: got %b %h want 1 bfc00108", inst_req, inst_addr);
        end
    endtask

    task automatic test_flush_wait();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok  = 1'b0;
        flush         = 1'b1;
        exc_pc        = 32'hBFC0_0380;
        branch_valid  = 1'b1;
        branch_target = 32'hBFC0_0500;
        cyc();
        flush        = 1'b0;
        branch_valid = 1'b0;
        n_cmp++;
        if (inst_req !== 1'b0 || fetch_stall !== 1'b1) begin
            n_bad++; $display("[TB] FAIL flush_discard: got req=%b fs=%b want 0 1", inst_req, fetch_stall);
        end
        cyc();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        cyc();
        inst_data_ok = 1'b0;
        n_cmp++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380 || Instruction !== 32'h0000_4444) begin
            n_bad++; $display("[TB] FAIL flush_stale: got %b %h %h want 1 bfc00380 00004444", inst_req, inst_addr, Instruction);
        end
        do_fetch(32'h0000_5555);
        n_cmp++;
        if (Instruction !== 32'h0000_5555 || is_delayslot !== 1'b0 || PC_plus4 !== 32'hBFC0_0384) begin
            n_bad++; $display("[TB] FAIL flush_fetch: got %h %b %h want 00005555 0 bfc00384", Instruction, is_delayslot, PC_plus4);
        end
        cyc();
        n_cmp++;
        if (inst_addr !== 32'hBFC0_0384) begin
            n_bad++; $display("[TB] FAIL flush_nobranch: got %h want bfc00384", inst_addr);
        end
    endtask

    task automatic test_misaligned();
        flush  = 1'b1;
        exc_pc = 32'hBFC0_0382;
        cyc();
        flush = 1'b0;
        n_cmp++;
        if (inst_req !== 1'b0 || inst_addr !== 32'hBFC0_0382) begin
            n_bad++; $display("[TB] FAIL adel_noreq: got %b %h want 0 bfc00382", inst_req, inst_addr);
        end
        cyc();
        n_cmp++;
        if (Instruction !== 32'h0 || if_fetch_exc_type !== 32'h0000_0004 ||
            PC_plus4 !== 32'hBFC0_0386 || fetch_stall !== 1'b0) begin
            n_bad++; $display("[TB] FAIL adel_deliver: got %h %h %h fs=%b want 0 4 bfc00386 0",
                              Instruction, if_fetch_exc_type, PC_plus4, fetch_stall);
        end
        cyc();
        flush  = 1'b1;
        exc_pc = 32'hFFFF_FFFC;
        cyc();
        flush = 1'b0;
    endtask

    task automatic test_wrap();
        do_fetch(32'h0000_6666);
        n_cmp++;
        if (PC_plus4 !== 32'h0 || if_fetch_exc_type !== 32'h0 || Instruction !== 32'h0000_6666) begin
            n_bad++; $display("[TB] FAIL wrap_plus4: got %h %h %h want 0 0 00006666", PC_plus4, if_fetch_exc_type, Instruction);
        end
        cyc();
        n_cmp++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
            n_bad++; $display("[TB] FAIL wrap_addr: got %b %h want 1 00000000", inst_req, inst_addr);
        end
    endtask

    task automatic test_back_to_back();
        // Accept and flush in the same cycle: the request still returns data.
        inst_addr_ok = 1'b1;
        flush        = 1'b1;
        exc_pc       = 32'hBFC0_0400;
        cyc();
        inst_addr_ok = 1'b0;
        flush        = 1'b0;
        n_cmp++;
        if (inst_req !== 1'b0 || fetch_stall !== 1'b1) begin
            n_bad++; $display("[TB] FAIL accflush_discard: got req=%b fs=%b want 0 1", inst_req, fetch_stall);
        end
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0000_0BAD;
        cyc();
        inst_data_ok = 1'b0;
        n_cmp++;
        if (inst_addr !== 32'hBFC0_0400 || inst_req !== 1'b1 || Instruction !== 32'h0000_6666) begin
            n_bad++; $display("[TB] FAIL accflush_resume: got %h %b %h want bfc00400 1 00006666", inst_addr, inst_req, Instruction);
        end
    endtask

    task automatic test_reset_in_wait();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        rst          = 1'b1;
        cyc();
        rst          = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0000_7777;
        cyc();
        inst_data_ok = 1'b0;
        n_cmp++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000 ||
            Instruction !== 32'h0 || fetch_stall !== 1'b1) begin
            n_bad++; $display("[TB] FAIL reset_wait: got %b %h %h fs=%b want 1 bfc00000 0 1",
                              inst_req, inst_addr, Instruction, fetch_stall);
        end
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        exc_pc        = 32'h0;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        inst_addr_ok  = 1'b0;
        inst_data_ok  = 1'b0;
        inst_rdata    = 32'h0;
        test_reset();
        test_basic();
        test_delayslot();
        test_stall();
        test_flush_wait();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  in  1  downstream hold (OR of ID/EX/MEM stalls); hold the delivered instruction.
REQ-004 SHALL have port flush  in  1  exception/eret redirect; highest priority.
REQ-005 SHALL have port exc_pc  in  32  redirect target, sampled when flush=1.
REQ-006 SHALL have port branch_valid  in  1  taken branch/jump resolved in ID this cycle.
REQ-007 SHALL have port branch_target  in  32  target, sampled when branch_valid=1.
REQ-008 SHALL have port inst_req  out  1  memory request valid.
REQ-009 SHALL have port inst_addr  out  32  request address (current PC).
REQ-010 SHALL have port inst_addr_ok  in  1  request accepted this cycle.
REQ-011 SHALL have port inst_data_ok  in  1  read data valid this cycle.
REQ-012 SHALL have port inst_rdata  in  32  read data.
REQ-013 SHALL have port PC_plus4  out  32  fetched PC + 4.
REQ-014 SHALL have port Instruction  out  32  fetched word.
REQ-015 SHALL have port is_delayslot  out  1  delivered instruction is a branch delay slot.
REQ-016 SHALL have port if_fetch_exc_type  out  32  fetch exception code.
REQ-017 SHALL have port fetch_stall  out  1  no valid instruction presented; feeds IF/ID stall.

Function
REQ-018 SHALL implement states ISSUE (inst_req=1), WAIT (request accepted, awaiting data), HOLD (data captured, waiting for stall=0), DISCARD (awaiting data of a flushed request).
REQ-019 SHALL, in ISSUE with PC[1:0]=00, assert inst_req with inst_addr=PC and go to WAIT when inst_addr_ok=1, otherwise stay in ISSUE.
REQ-020 SHALL, in ISSUE with PC[1:0]!=00, not assert inst_req, produce Instruction=0 and if_fetch_exc_type=32'h0000_0004 (AdEL), and go directly to HOLD.
REQ-021 SHALL, in WAIT on inst_data_ok=1, capture inst_rdata into Instruction, PC+4 into PC_plus4, and if_fetch_exc_type=0, then go to HOLD.
REQ-022 SHALL, in HOLD, drive fetch_stall=0; fetch_stall=1 in ISSUE, WAIT and DISCARD.
REQ-023 SHALL, in HOLD with stall=0, update PC to the pending redirect target if one is latched, else PC+4, clear the pending redirect, and return to ISSUE next cycle (one delivered instruction per HOLD exit).
REQ-024 SHALL, in HOLD with stall=1, keep every output and PC unchanged.
REQ-025 SHALL latch branch_valid/branch_target into a one-entry pending-redirect register in any state; the instruction currently being fetched or held is the delay slot, so its is_delayslot SHALL be 1 when delivered.
REQ-026 SHALL ignore branch_valid while a pending redirect is already latched (the first branch wins).
REQ-027 SHALL, on flush=1, set PC=exc_pc, clear the pending redirect and is_delayslot, and go to ISSUE from ISSUE/HOLD, or to DISCARD from WAIT; same-cycle branch_valid SHALL be ignored.
REQ-028 SHALL, in DISCARD, drop the returning data (no output update) and go to ISSUE when inst_data_ok=1; a flush in DISCARD only updates PC.
REQ-029 SHALL, when inst_addr_ok and flush are both 1 in ISSUE, treat the request as accepted and enter DISCARD.
REQ-030 SHALL compute PC+4 modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000, no exception).
REQ-031 SHALL keep inst_addr stable while inst_req=1 and inst_addr_ok=0.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, set PC=32'hBFC0_0000, state=ISSUE, PC_plus4=0, Instruction=0, is_delayslot=0, if_fetch_exc_type=0, pending redirect cleared; fetch_stall=1.
REQ-033 SHALL let reset override any state, including WAIT/DISCARD; a data_ok arriving in the first cycle after reset for a pre-reset request SHALL be ignored (the state is ISSUE).

Verification
REQ-034 SHALL cover: reset, addr_ok=1 at cycle 1, data_ok with rdata=0x2408_0001 at cycle 3 -> inst_addr=0xBFC0_0000, Instruction=0x2408_0001, PC_plus4=0xBFC0_0004, fetch_stall=0; next inst_addr=0xBFC0_0004.
REQ-035 SHALL cover: branch_valid target=0xBFC0_0100 during fetch of 0xBFC0_0008 -> that instruction is delivered with is_delayslot=1; the next inst_addr=0xBFC0_0100 with is_delayslot=0.
REQ-036 SHALL cover: stall=1 for 3 cycles in HOLD -> outputs frozen, no inst_req; after release, the next request is issued in 1 cycle.
REQ-037 SHALL cover: flush with exc_pc=0xBFC0_0380 in WAIT, stale data_ok 2 cycles later -> stale data not delivered; the next inst_addr=0xBFC0_0380.
REQ-038 SHALL cover: flush with exc_pc=0xBFC0_0382 -> no inst_req; delivered Instruction=0, if_fetch_exc_type=0x0000_0004, PC_plus4=0xBFC0_0386.
